mpmc11_req_fetch: RTL and testbench

// Read-side consumer of the mpmc11 request async FIFO. Runs in the memory-controller clock domain.

---
 rtl/mpmc11_req_fetch.sv | 114 +++++++++++
 tb/tb_mpmc11_req_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc11_req_fetch.sv
// mpmc11 request fetch: drains the request async FIFO into a small head buffer.
// Define MPMC11_REQ_FETCH_PREFETCH_EN for a 2-entry buffer; default is 1 entry.
package mpmc11_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic        we;
    logic [26:0] addr;
    logic [31:0] wdata;
  } mpmc11_fifoe_t;
  localparam int FIFOE_W = $bits(mpmc11_fifoe_t);
endpackage

module mpmc11_req_fetch
  import mpmc11_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  input  logic               fifo_v,
  input  logic               fifo_rst_busy,
  input  logic [FIFOE_W-1:0] req_fifoi,
  output logic               rd_fifo,
  input  logic               hold,
  output logic [FIFOE_W-1:0] req_o,
  output logic               req_v,
  input  logic               req_rdy,
  output logic [1:0]         occ,
  output logic               err
);
`ifdef MPMC11_REQ_FETCH_PREFETCH_EN
  localparam logic [1:0] NENT = 2'd2;
`else
  localparam logic [1:0] NENT = 2'd1;
`endif

  typedef enum logic [1:0] {ST_WAIT, ST_RUN, ST_HOLD} state_t;

  state_t             state_q;
  logic [FIFOE_W-1:0] head_q, head_d;
`ifdef MPMC11_REQ_FETCH_PREFETCH_EN
  logic [FIFOE_W-1:0] tail_q, tail_d;
`endif
  logic [1:0]         occ_q, occ_d, occ_p, fill;
  logic               req_v_q;
  logic               inflight_q, inflight_d;
  logic               err_q;
  logic               pop, cap;

  assign pop  = req_v_q & req_rdy;
  assign cap  = fifo_v & inflight_q;
  assign fill = occ_q + {1'b0, inflight_q};

  // A slot is reserved at issue time so a returning read always has room.
  assign rd_fifo = (state_q == ST_RUN) & ~fifo_empty
                 & ~fifo_rst_busy & ~rst
                 & ((fill < NENT) | ((fill == NENT) & pop))
                 & (~inflight_q | fifo_v);

  always_comb begin
    occ_p  = occ_q - {1'b0, pop};
    head_d = head_q;
`ifdef MPMC11_REQ_FETCH_PREFETCH_EN
    tail_d = tail_q;
    if (pop && occ_q == 2'd2) head_d = tail_q;
    if (cap && occ_p == 2'd1) tail_d = req_fifoi;
`endif
    if (cap && occ_p == 2'd0) head_d = req_fifoi;
    occ_d      = occ_p + {1'b0, cap};
    inflight_d = rd_fifo | (inflight_q & ~fifo_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      head_q     <= '0;
`ifdef MPMC11_REQ_FETCH_PREFETCH_EN
      tail_q     <= '0;
`endif
      occ_q      <= '0;
      req_v_q    <= 1'b0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      assert (!(cap && occ_p == NENT));
      if (fifo_v && !inflight_q) err_q <= 1'b1;
      head_q <= head_d;
`ifdef MPMC11_REQ_FETCH_PREFETCH_EN
      tail_q <= tail_d;
`endif
      if (fifo_rst_busy) begin
        state_q    <= ST_WAIT;
        occ_q      <= '0;
        req_v_q    <= 1'b0;
        inflight_q <= 1'b0;
      end else begin
        occ_q      <= occ_d;
        req_v_q    <= (occ_d != 2'd0);
        inflight_q <= inflight_d;
        unique case (state_q)
          ST_WAIT: state_q <= ST_RUN;
          ST_RUN:  if (hold) state_q <= ST_HOLD;
          ST_HOLD: if (!hold) state_q <= ST_RUN;
          default: state_q <= ST_WAIT;
        endcase
      end
    end
  end

  assign req_o = head_q;
  assign req_v = req_v_q;
  assign occ   = occ_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mpmc11_req_fetch.sv
// Directed scoreboard bench for mpmc11_req_fetch.
// A 1-cycle-latency FIFO model feeds the DUT; deliveries are checked in order.
module tb_mpmc11_req_fetch;
  import mpmc11_pkg::*;
  localparam int W = FIFOE_W;
`ifdef MPMC11_REQ_FETCH_PREFETCH_EN
  localparam int NE   = 2;
  localparam int SPAN = 7;
`else
  localparam int NE   = 1;
  localparam int SPAN = 14;
`endif

  logic         clk = 1'b0;
  logic         rst, fifo_rst_busy, hold, req_rdy, inj_v;
  logic [W-1:0] inj_d;
  logic [W-1:0] mdl_d = '0;
  logic         mdl_v = 1'b0;
  logic         fempty = 1'b1;
  logic [W-1:0] req_fifoi, req_o;
  logic         fifo_v, rd_fifo, req_v, err;
  logic [1:0]   occ;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           dcyc[$];
  int           cyc = 0;
  int           ndel = 0;
  int           checks = 0;
  int           failures = 0;
  int           c1, n0;

  always #5 clk = ~clk;

  assign fifo_v    = mdl_v | inj_v;
  assign req_fifoi = inj_v ? inj_d : mdl_d;

  mpmc11_req_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fempty),
    .fifo_v        (fifo_v),
    .fifo_rst_busy (fifo_rst_busy),
    .req_fifoi     (req_fifoi),
    .rd_fifo       (rd_fifo),
    .hold          (hold),
    .req_o         (req_o),
    .req_v         (req_v),
    .req_rdy       (req_rdy),
    .occ           (occ),
    .err           (err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_fifo && fq.size() != 0) begin
      mdl_v <= 1'b1;
      mdl_d <= fq.pop_front();
    end else begin
      mdl_v <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    fempty = (fq.size() == 0);
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] mk(input int i);
    mk = {32'hA5A50000 + 32'(i), 32'h00001000 + 32'(i * 3)};
  endfunction

  task automatic push(input int i);
    fq.push_back(mk(i));
    exp_q.push_back(mk(i));
  endtask

  task automatic wait_del(input int n, input int budget,
                          input string tag);
    for (int i = 0; i < budget && ndel < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, W'(ndel), W'(n));
  endtask

  always @(negedge clk) begin
    if (!rst && req_v && req_rdy) begin
      chk("deliv_has_exp", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) chk("deliv_data", req_o, exp_q.pop_front());
      dcyc.push_back(cyc);
      ndel++;
    end
  end

  initial begin
    rst = 1'b1;
    fifo_rst_busy = 1'b1;
    hold = 1'b0;
    req_rdy = 1'b1;
    inj_v = 1'b0;
    inj_d = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push(i);
    @(negedge clk);
    chk("rst_req_v", W'(req_v), W'(0));
    chk("rst_occ", W'(occ), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_req_o", req_o, W'(0));
    chk("rst_rd", W'(rd_fifo), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_rd", W'(rd_fifo), W'(0));
    end

    @(posedge clk);
    #1;
    fifo_rst_busy = 1'b0;
    @(negedge clk);
    chk("wait_rd", W'(rd_fifo), W'(0));
    @(negedge clk);
    chk("first_rd", W'(rd_fifo), W'(1));
    c1 = cyc;
    wait_del(8, 60, "burst_cnt");
    if (dcyc.size() >= 8) begin
      chk("burst_lat", W'(dcyc[0]), W'(c1 + 2));
      chk("burst_span", W'(dcyc[7] - dcyc[0]), W'(SPAN));
    end

    @(posedge clk);
    #1;
    req_rdy = 1'b0;
    for (int i = 8; i < 12; i++) push(i);
    repeat (10) @(negedge clk);
    chk("stall_occ", W'(occ), W'(NE));
    chk("stall_rd", W'(rd_fifo), W'(0));
    chk("stall_v", W'(req_v), W'(1));
    chk("stall_head", req_o, mk(8));
    repeat (3) @(negedge clk);
    chk("stall_stable", req_o, mk(8));
    @(posedge clk);
    #1;
    req_rdy = 1'b1;
    wait_del(12, 40, "stall_cnt");
    chk("stall_drain", W'(exp_q.size()), W'(0));

    @(posedge clk);
    #1;
    for (int i = 12; i < 16; i++) push(i);
    #2;
    chk("hold_rd", W'(rd_fifo), W'(1));
    hold = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("hold_cap", W'(ndel), W'(13));
    chk("hold_occ", W'(occ), W'(0));
    @(negedge clk);
    chk("hold_rd_off", W'(rd_fifo), W'(0));
    @(posedge clk);
    #1;
    hold = 1'b0;
    wait_del(16, 40, "resume_cnt");
    chk("resume_err", W'(err), W'(0));

    repeat (2) @(posedge clk);
    #1;
    inj_d = mk(99);
    inj_v = 1'b1;
    @(posedge clk);
    #1;
    inj_v = 1'b0;
    @(negedge clk);
    chk("err_set", W'(err), W'(1));
    chk("err_occ", W'(occ), W'(0));
    chk("err_v", W'(req_v), W'(0));
    repeat (5) @(negedge clk);
    chk("err_sticky", W'(err), W'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("err_rst", W'(err), W'(0));

    @(posedge clk);
    #1;
    req_rdy = 1'b0;
    for (int i = 16; i < 20; i++) push(i);
    repeat (8) @(negedge clk);
    chk("flush_pre_occ", W'(occ), W'(NE));
    @(posedge clk);
    #1;
    fifo_rst_busy = 1'b1;
    @(negedge clk);
    chk("flush_pre_v", W'(req_v), W'(1));
    @(negedge clk);
    chk("flush_v", W'(req_v), W'(0));
    chk("flush_occ", W'(occ), W'(0));
    chk("flush_rd", W'(rd_fifo), W'(0));
    @(posedge clk);
    #1;
    fq.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    fifo_rst_busy = 1'b0;
    n0 = ndel;
    for (int i = 20; i < 24; i++) push(i);
    req_rdy = 1'b1;
    wait_del(n0 + 4, 40, "recover_cnt");
    chk("recover_drain", W'(exp_q.size()), W'(0));
    chk("final_err", W'(err), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
